trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 4, number of cycles flush_o is held in FLUSH state (legal 1..15).
REQ-002 SHALL have port clk_i input 1 — single clock; all state on rising edge.
REQ-003 SHALL have port rst_ni input 1 — reset, asynchronous, active-low.
REQ-004 SHALL have port exc_valid_i input 1 — synchronous exception request from pipeline.
REQ-005 SHALL have port exc_pc_i input 32 — pc of the faulting instruction.
REQ-006 SHALL have port exc_mcause_i input 31 — exception cause code.
REQ-007 SHALL have port irq_i input 1 — machine external interrupt, level.
REQ-008 SHALL have port irq_pc_i input 32 — pc of the next instruction to retire, used as return pc for an interrupt.
REQ-009 SHALL have port mret_i input 1 — MRET retiring.
REQ-010 SHALL have port trap_handler_addr_i input 32 — handler base from the CSR file.
REQ-011 SHALL have port mepc_i input 32 — current mepc from the CSR file.
REQ-012 SHALL have port redirect_ready_i input 1 — fetch accepts the redirect.
REQ-013 SHALL have port trap_valid_o output 1 — one-cycle trap commit pulse to the CSR file.
REQ-014 SHALL have port trap_pc_o output 32 — captured trap pc.
REQ-015 SHALL have port trap_mcause_o output 31 — captured cause.
REQ-016 SHALL have port trap_is_interrupt_o output 1 — captured interrupt flag.
REQ-017 SHALL have port flush_o output 1 — kill all in-flight pipeline instructions.
REQ-018 SHALL have port redirect_valid_o output 1 — redirect request to fetch.
REQ-019 SHALL have port redirect_pc_o output 32 — redirect target.
REQ-020 SHALL have port busy_o output 1 — high whenever the state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, CAPTURE, FLUSH and REDIRECT.
REQ-022 SHALL sample events only in IDLE; events in any other state are ignored and not queued.
REQ-023 SHALL give simultaneous events the priority exc_valid_i > irq_i > mret_i.
REQ-024 SHALL, when IDLE accepts an exception, register exc_pc_i, exc_mcause_i and is_interrupt=0, then enter CAPTURE next cycle.
REQ-025 SHALL, when IDLE accepts an interrupt, register irq_pc_i, mcause=11 and is_interrupt=1, then enter CAPTURE.
REQ-026 SHALL, when IDLE accepts an MRET, register target mepc_i, skip CAPTURE, enter FLUSH, and never assert trap_valid_o.
REQ-027 SHALL, in CAPTURE, assert trap_valid_o for exactly that one cycle with trap_pc_o, trap_mcause_o and trap_is_interrupt_o valid, then enter FLUSH.
REQ-028 SHALL hold trap_pc_o, trap_mcause_o and trap_is_interrupt_o stable from CAPTURE until the next accepted trap; they are 0 after reset.
REQ-029 SHALL stay in FLUSH for exactly FLUSH_CYCLES cycles using a 4-bit down counter, then enter REDIRECT.
REQ-030 SHALL, on entry to REDIRECT, latch redirect_pc_o = {trap_handler_addr_i[31:2],2'b00} for a trap, or the registered mepc for MRET.
REQ-031 SHALL assert flush_o in CAPTURE, FLUSH and REDIRECT, and deassert it in IDLE.
REQ-032 SHALL assert redirect_valid_o throughout REDIRECT with redirect_pc_o held stable until redirect_valid_o && redirect_ready_i, then return to IDLE next cycle.
REQ-033 SHALL complete the REDIRECT handshake in one cycle when redirect_ready_i is already high on REDIRECT entry.
REQ-034 SHALL give an exception end-to-end latency, accept to first redirect_valid_o, of 1+FLUSH_CYCLES+1 cycles; MRET latency is FLUSH_CYCLES+1 cycles.
REQ-035 SHALL allow a new event to be accepted in the first IDLE cycle after the handshake (back-to-back).

Reset
REQ-036 SHALL, on asynchronous assertion of rst_ni at any time including mid-flush or mid-redirect, force state to IDLE, the counter to 0 and every output to 0 immediately.
REQ-037 SHALL leave reset synchronously on the first rising edge with rst_ni high, and accept no event in that same cycle.

Configuration
REQ-038 SHALL, with TRAP_CTRL_IRQ_EN defined, honour irq_i per REQ-023/REQ-025.
REQ-039 SHALL, without TRAP_CTRL_IRQ_EN, ignore irq_i and irq_pc_i entirely, and hold trap_is_interrupt_o at constant 0.

Verification
REQ-040 SHALL cover: exc_valid_i=1, pc=0x0000_0100, mcause=2, handler=0x0000_0803, FLUSH_CYCLES=4, ready=1 -> trap_valid_o pulse cycle 1, flush_o cycles 1-6, redirect_pc_o=0x0000_0800 cycle 6, IDLE cycle 7.
REQ-041 SHALL cover: mret_i=1, mepc_i=0x0000_0104 -> no trap_valid_o, redirect_valid_o cycle 5, redirect_pc_o=0x0000_0104.
REQ-042 SHALL cover: exc_valid_i, irq_i and mret_i all set in the same cycle -> exception captured with is_interrupt=0; with TRAP_CTRL_IRQ_EN and irq_i alone, mcause=11 and is_interrupt=1.
REQ-043 SHALL cover: redirect_ready_i held low for 3 cycles in REDIRECT -> redirect_valid_o and redirect_pc_o stable for 4 cycles, exc_valid_i pulses during that time ignored.
REQ-044 SHALL cover: rst_ni dropped during FLUSH -> flush_o=0, busy_o=0 without waiting for a clock edge, no redirect after release.
REQ-045 SHALL cover: without TRAP_CTRL_IRQ_EN, irq_i=1 for 10 cycles -> busy_o stays 0.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer: captures an exception/interrupt/MRET, pulses the CSR commit,
// flushes the pipeline, then redirects fetch. Optional interrupt path: TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_pc_i,
  input  logic [30:0] exc_mcause_i,
  input  logic        irq_i,
  input  logic [31:0] irq_pc_i,
  input  logic        mret_i,
  input  logic [31:0] trap_handler_addr_i,
  input  logic [31:0] mepc_i,
  input  logic        redirect_ready_i,
  output logic        trap_valid_o,
  output logic [31:0] trap_pc_o,
  output logic [30:0] trap_mcause_o,
  output logic        trap_is_interrupt_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        armed;
  logic        is_mret;
  logic [31:0] mret_pc;

  // Handler alignment bits are dropped; irq inputs are dead when the irq path is compiled out.
  wire unused_ok = ^{irq_i, irq_pc_i, trap_handler_addr_i[1:0]};

  assign state_o = state;

  // Redirect handshake: redirect_valid_o rises on REDIRECT entry and stays high with
  // redirect_pc_o frozen; the transfer happens on any edge where valid && ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state               <= IDLE;
      cnt                 <= 4'd0;
      armed               <= 1'b0;
      is_mret             <= 1'b0;
      mret_pc             <= 32'd0;
      trap_valid_o        <= 1'b0;
      trap_pc_o           <= 32'd0;
      trap_mcause_o       <= 31'd0;
      trap_is_interrupt_o <= 1'b0;
      flush_o             <= 1'b0;
      redirect_valid_o    <= 1'b0;
      redirect_pc_o       <= 32'd0;
      busy_o              <= 1'b0;
    end else begin
      // The first edge out of reset only arms event sampling.
      armed        <= 1'b1;
      trap_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (armed) begin
            if (exc_valid_i) begin
              trap_pc_o           <= exc_pc_i;
              trap_mcause_o       <= exc_mcause_i;
              trap_is_interrupt_o <= 1'b0;
              is_mret             <= 1'b0;
              trap_valid_o        <= 1'b1;
              flush_o             <= 1'b1;
              busy_o              <= 1'b1;
              state               <= CAPTURE;
`ifdef TRAP_CTRL_IRQ_EN
            end else if (irq_i) begin
              trap_pc_o           <= irq_pc_i;
              trap_mcause_o       <= 31'd11;
              trap_is_interrupt_o <= 1'b1;
              is_mret             <= 1'b0;
              trap_valid_o        <= 1'b1;
              flush_o             <= 1'b1;
              busy_o              <= 1'b1;
              state               <= CAPTURE;
`endif
            end else if (mret_i) begin
              mret_pc <= mepc_i;
              is_mret <= 1'b1;
              cnt     <= CNT_LOAD;
              flush_o <= 1'b1;
              busy_o  <= 1'b1;
              state   <= FLUSH;
            end
          end
        end
        CAPTURE: begin
          cnt   <= CNT_LOAD;
          state <= FLUSH;
        end
        FLUSH: begin
          if (cnt == 4'd0) begin
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= is_mret ? mret_pc : {trap_handler_addr_i[31:2], 2'b00};
            state            <= REDIRECT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: vector table for the main sequences plus hand-written
// corner cases (stalled redirect, reset mid-flush, reset release, irq path).
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        exc_valid_i = 1'b0;
  logic [31:0] exc_pc_i = 32'd0;
  logic [30:0] exc_mcause_i = 31'd0;
  logic        irq_i = 1'b0;
  logic [31:0] irq_pc_i = 32'h0000_0200;
  logic        mret_i = 1'b0;
  logic [31:0] trap_handler_addr_i = 32'h0000_0803;
  logic [31:0] mepc_i = 32'h0000_0104;
  logic        redirect_ready_i = 1'b1;
  logic        trap_valid_o;
  logic [31:0] trap_pc_o;
  logic [30:0] trap_mcause_o;
  logic        trap_is_interrupt_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  trap_ctrl #(.FLUSH_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i), .exc_mcause_i(exc_mcause_i),
    .irq_i(irq_i), .irq_pc_i(irq_pc_i), .mret_i(mret_i),
    .trap_handler_addr_i(trap_handler_addr_i), .mepc_i(mepc_i),
    .redirect_ready_i(redirect_ready_i),
    .trap_valid_o(trap_valid_o), .trap_pc_o(trap_pc_o), .trap_mcause_o(trap_mcause_o),
    .trap_is_interrupt_o(trap_is_interrupt_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every completed redirect handshake must match the next expected target
  always @(negedge clk) begin
    if (rst_ni && redirect_valid_o && redirect_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL redirect_unexpected: got %h want none", redirect_pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (redirect_pc_o !== e) begin
          bad++;
          $display("FAIL redirect_target: got %h want %h", redirect_pc_o, e);
        end
      end
    end
  end

  typedef struct {
    logic        exc, irq, mret, rdy;
    logic [31:0] pc;
    logic [30:0] cause;
    logic        e_tv, e_fl, e_rv, e_busy;
    logic [31:0] e_tpc;
    logic [30:0] e_cause;
    logic        e_int;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic exc, logic irq, logic mret, logic rdy,
                             logic [31:0] pc, logic [30:0] cause,
                             logic tv, logic fl, logic rv, logic b,
                             logic [31:0] tpc, logic [30:0] tc, logic ti, logic [31:0] rpc);
    vec_t r;
    r.exc = exc; r.irq = irq; r.mret = mret; r.rdy = rdy; r.pc = pc; r.cause = cause;
    r.e_tv = tv; r.e_fl = fl; r.e_rv = rv; r.e_busy = b;
    r.e_tpc = tpc; r.e_cause = tc; r.e_int = ti; r.e_rpc = rpc;
    return r;
  endfunction

  task automatic drive_idle();
    exc_valid_i = 1'b0; irq_i = 1'b0; mret_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20 && busy_o; i++) tick();
    chk(nm, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    // exception path A, back-to-back MRET B, all-events priority C (with ignored pulse)
    vq.push_back(v(1,0,0,1, 32'h100, 31'd2, 1,1,0,1, 32'h100, 31'd2, 0, 32'h0));
    for (int i = 0; i < 4; i++)
      vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,1,0,1, 32'h100, 31'd2, 0, 32'h0));
    vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,1,1,1, 32'h100, 31'd2, 0, 32'h800));
    vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,0,0,0, 32'h100, 31'd2, 0, 32'h800));
    vq.push_back(v(0,0,1,1, 32'h0, 31'd0, 0,1,0,1, 32'h100, 31'd2, 0, 32'h800));
    for (int i = 0; i < 3; i++)
      vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,1,0,1, 32'h100, 31'd2, 0, 32'h800));
    vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,1,1,1, 32'h100, 31'd2, 0, 32'h104));
    vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,0,0,0, 32'h100, 31'd2, 0, 32'h104));
    vq.push_back(v(1,1,1,1, 32'h300, 31'd5, 1,1,0,1, 32'h300, 31'd5, 0, 32'h104));
    vq.push_back(v(1,0,0,1, 32'h400, 31'd7, 0,1,0,1, 32'h300, 31'd5, 0, 32'h104));
    for (int i = 0; i < 3; i++)
      vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,1,0,1, 32'h300, 31'd5, 0, 32'h104));
    vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,1,1,1, 32'h300, 31'd5, 0, 32'h800));
    vq.push_back(v(0,0,0,1, 32'h0, 31'd0, 0,0,0,0, 32'h300, 31'd5, 0, 32'h800));
    exp_q.push_back(32'h800);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h800);

    // reset state
    tick(); tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_trap_pc", trap_pc_o, 32'd0);
    chk("rst_rpc", redirect_pc_o, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    rst_ni = 1'b1;
    tick(); tick();

    foreach (vq[k]) begin
      exc_valid_i = vq[k].exc; irq_i = vq[k].irq; mret_i = vq[k].mret;
      redirect_ready_i = vq[k].rdy; exc_pc_i = vq[k].pc; exc_mcause_i = vq[k].cause;
      tick();
      chk($sformatf("v%0d_trap_valid", k), {31'd0, trap_valid_o}, {31'd0, vq[k].e_tv});
      chk($sformatf("v%0d_flush", k), {31'd0, flush_o}, {31'd0, vq[k].e_fl});
      chk($sformatf("v%0d_redir_valid", k), {31'd0, redirect_valid_o}, {31'd0, vq[k].e_rv});
      chk($sformatf("v%0d_busy", k), {31'd0, busy_o}, {31'd0, vq[k].e_busy});
      chk($sformatf("v%0d_trap_pc", k), trap_pc_o, vq[k].e_tpc);
      chk($sformatf("v%0d_mcause", k), {1'b0, trap_mcause_o}, {1'b0, vq[k].e_cause});
      chk($sformatf("v%0d_is_irq", k), {31'd0, trap_is_interrupt_o}, {31'd0, vq[k].e_int});
      chk($sformatf("v%0d_redir_pc", k), redirect_pc_o, vq[k].e_rpc);
    end
    drive_idle();

    // stalled redirect: ready low for 3 cycles, exception pulses ignored
    redirect_ready_i = 1'b0;
    exc_valid_i = 1'b1; exc_pc_i = 32'h700; exc_mcause_i = 31'd1;
    tick();
    exc_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_rv0", {31'd0, redirect_valid_o}, 32'd1);
    chk("stall_rpc0", redirect_pc_o, 32'h800);
    exp_q.push_back(32'h800);
    for (int k = 0; k < 3; k++) begin
      exc_valid_i = (k != 1); exc_pc_i = 32'h900;
      tick();
      chk($sformatf("stall_rv%0d", k + 1), {31'd0, redirect_valid_o}, 32'd1);
      chk($sformatf("stall_rpc%0d", k + 1), redirect_pc_o, 32'h800);
      chk($sformatf("stall_tpc%0d", k + 1), trap_pc_o, 32'h700);
    end
    exc_valid_i = 1'b0; redirect_ready_i = 1'b1;
    tick();
    chk("stall_done_rv", {31'd0, redirect_valid_o}, 32'd0);
    chk("stall_done_busy", {31'd0, busy_o}, 32'd0);
    tick();
    chk("stall_not_queued", {31'd0, busy_o}, 32'd0);

    // asynchronous reset in the middle of FLUSH
    exc_valid_i = 1'b1; exc_pc_i = 32'h600; exc_mcause_i = 31'd4;
    tick();
    exc_valid_i = 1'b0;
    tick(); tick();
    chk("pre_rst_flush", {31'd0, flush_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_flush", {31'd0, flush_o}, 32'd0);
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("async_rst_tpc", trap_pc_o, 32'd0);
    chk("async_rst_state", {30'd0, state_o}, 32'd0);
    @(negedge clk) rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_redirect", {30'd0, redirect_valid_o, busy_o}, 32'd0);
    end

`ifdef TRAP_CTRL_IRQ_EN
    irq_i = 1'b1;
    tick();
    irq_i = 1'b0;
    chk("irq_tv", {31'd0, trap_valid_o}, 32'd1);
    chk("irq_tpc", trap_pc_o, 32'h200);
    chk("irq_mcause", {1'b0, trap_mcause_o}, 32'd11);
    chk("irq_flag", {31'd0, trap_is_interrupt_o}, 32'd1);
    exp_q.push_back(32'h800);
    wait_idle("irq_drain");
`else
    irq_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("irq_off_busy", {31'd0, busy_o}, 32'd0);
      chk("irq_off_flag", {31'd0, trap_is_interrupt_o}, 32'd0);
    end
    irq_i = 1'b0;
`endif

    // reset release: the first edge with rst_ni high accepts nothing
    tick();
    rst_ni = 1'b0;
    exc_valid_i = 1'b1; exc_pc_i = 32'h500; exc_mcause_i = 31'd3;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    chk("release_edge_busy", {31'd0, busy_o}, 32'd0);
    chk("release_edge_tv", {31'd0, trap_valid_o}, 32'd0);
    tick();
    exc_valid_i = 1'b0;
    chk("release_next_tv", {31'd0, trap_valid_o}, 32'd1);
    chk("release_next_tpc", trap_pc_o, 32'h500);
    exp_q.push_back(32'h800);
    wait_idle("release_drain");

    tick();
    chk("redirects_all_seen", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
